hilo_ctrl: RTL
==============

# hilo_ctrl

Issue-side controller for the multiply/divide unit. It sits in the EX stage and owns the architectural HI/LO registers. It decodes MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO, drives the unit's start/operand/mode inputs, and waits on its busy flag. It stalls the pipeline until the result is written into HI/LO.

## Interface
- WIDTH, 32, operand/HI/LO width
- TMO, 16, completion timeout in WAIT cycles (used only with HILO_TIMEOUT_EN)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op_valid  in  1  EX-stage instruction valid
- op  in  4  0000 MULT, 0001 DIV, 1000 MULTU, 1001 DIVU, 0100 MTHI, 0101 MTLO, 0110 MFHI, 0111 MFLO, others NOP
- rs_val  in  WIDTH  rs operand
- rt_val  in  WIDTH  rt operand
- stall  out  1  hold pipeline
- mf_data  out  WIDTH  MFHI/MFLO read data
- du_a  out  WIDTH  unit input a (divisor / multiplicand B side), registered
- du_b  out  WIDTH  unit input b (dividend), registered
- du_m  out  4  unit mode, registered, same encoding as op[3:0]
- du_en  out  1  unit start, one-cycle registered pulse
- du_hi  in  WIDTH  unit HI result
- du_lo  in  WIDTH  unit LO result
- du_ff  in  1  unit busy flag
- err  out  1  sticky timeout flag

## Operation
- States: IDLE, ISSUE, WAIT, WRITE.
- IDLE with op_valid and a mul/div op (accept):
  - du_b <= rs_val, du_a <= rt_val, du_m <= op.
  - Next state ISSUE.
- ISSUE:
  - du_en = 1 for this cycle only.
  - Clear the ff_q history and the WAIT counter.
  - Next state WAIT.
- WAIT:
  - ff_q <= du_ff.
  - Completion when ff_q=1 and du_ff=0 (falling busy). On that edge, HI <= du_hi and LO <= du_lo; next state WRITE.
- WRITE:
  - Single cycle; op/op_valid are ignored.
  - Next state IDLE.
- Operands du_a/du_b/du_m are held stable from ISSUE through WRITE; the unit samples continuously.
- MTHI/MTLO in IDLE with op_valid: HI or LO <= rs_val at the clock edge. No stall.
- MFHI/MFLO: mf_data = HI or LO, combinationally. Otherwise mf_data = 0.
- NOP, or op_valid=0: no state change.
- stall:
  - 1 combinationally in the accept cycle.
  - 1 in ISSUE and WAIT.
  - 0 in WRITE and IDLE.
- Division by zero is issued normally; whatever the unit returns is written.
- Quotient lands in LO and remainder in HI, as delivered by the unit.

## Timing
- Reset values:
  - State IDLE; HI = 0, LO = 0.
  - du_a = 0, du_b = 0, du_m = 0, du_en = 0.
  - ff_q = 0, err = 0, stall = 0, mf_data = 0.
- Cycle 0: accept. Cycle 1: ISSUE, du_en = 1. Cycle 2+: WAIT.
- With a unit whose busy flag is high for 6 cycles after start, HI/LO update at the end of cycle 8. WRITE occurs in cycle 9, with stall low.
- Total stall: accept cycle plus ISSUE plus all WAIT cycles.
- MFHI presented in the cycle after WRITE reads the new HI.
- du_ff low throughout WAIT (no rising edge seen): no completion. Only the timeout can exit.
- Asynchronous reset mid-operation returns all state to reset values immediately. du_en drops; no HI/LO write occurs.
- MTHI/MTLO are only accepted in IDLE. An MT* arriving while busy is held by stall upstream.

## Configuration
- HILO_TIMEOUT_EN defined:
  - A WAIT counter increments each WAIT cycle.
  - When the counter reaches TMO without completion: err <= 1 (sticky until reset), state -> IDLE, HI/LO unchanged, stall released.
- HILO_TIMEOUT_EN undefined:
  - No counter; WAIT persists until completion.
  - err is tied to 0.

## Test plan
- MULT rs=0xFFFFFFFE (-2), rt=0x00000003 with a behavioural unit (busy 6 cycles) -> du_m=0000, single du_en pulse in cycle 1, HI=0xFFFFFFFF, LO=0xFFFFFFFA, stall high exactly cycles 0-8.
- DIVU rs=100, rt=7 -> du_b=100, du_a=7, du_m=1001, LO=14, HI=2; then MFLO -> mf_data=14, MFHI -> mf_data=2.
- MTHI rs=0x12345678, then MTLO rs=0x9ABCDEF0, then MFHI/MFLO -> 0x12345678/0x9ABCDEF0, stall never asserted.
- MULTU 0xFFFFFFFF*0xFFFFFFFF with rst_n pulsed low during WAIT -> all outputs at reset values, HI=LO=0, next MULTU 2*3 completes with LO=6, HI=0.
- With HILO_TIMEOUT_EN, TMO=16: unit holds du_ff=1 indefinitely -> after 16 WAIT cycles err=1, stall=0, HI/LO unchanged; err stays 1 through later successful ops until reset.
- Back-to-back MULT 3*4 then DIV 13/4 -> second op accepted in the cycle after WRITE, LO=3, HI=1; a MULT held during WRITE is not re-issued (exactly two du_en pulses).

Source files
------------

// File: rtl/hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hilo_ctrl
// Description : EX-stage issue controller for the multiply/divide unit.
//               Owns the architectural HI/LO registers. Decodes
//               MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO. Launches the unit
//               with a one-cycle start pulse and stalls the pipeline until
//               the result has been written into HI/LO.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters  : WIDTH - operand / HI / LO width
//               TMO   - completion timeout in WAIT cycles (HILO_TIMEOUT_EN only)
// Macro       : HILO_TIMEOUT_EN - when defined, a WAIT-cycle counter aborts a
//               stuck operation after TMO cycles and sets the sticky err_o.
//               When undefined there is no counter and err_o is tied low.
// Ports       : clk         rising-edge clock
//               rst_n       asynchronous active-low reset
//               op_valid_i  EX-stage instruction valid
//               op_i        opcode (0000 MULT, 0001 DIV, 1000 MULTU,
//                           1001 DIVU, 0100 MTHI, 0101 MTLO, 0110 MFHI,
//                           0111 MFLO, others NOP)
//               rs_val_i    rs operand
//               rt_val_i    rt operand
//               stall_o     hold pipeline
//               mf_data_o   MFHI/MFLO read data (combinational)
//               du_a_o      unit input a (divisor / multiplicand), registered
//               du_b_o      unit input b (dividend), registered
//               du_m_o      unit mode (opcode encoding), registered
//               du_en_o     unit start, one-cycle registered pulse
//               du_hi_i     unit HI result (remainder for divides)
//               du_lo_i     unit LO result (quotient for divides)
//               du_ff_i     unit busy flag
//               err_o       sticky timeout flag
// ============================================================================
module hilo_ctrl #(
  parameter int WIDTH = 32,
  parameter int TMO   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid_i,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] rs_val_i,
  input  logic [WIDTH-1:0] rt_val_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] mf_data_o,
  output logic [WIDTH-1:0] du_a_o,
  output logic [WIDTH-1:0] du_b_o,
  output logic [3:0]       du_m_o,
  output logic             du_en_o,
  input  logic [WIDTH-1:0] du_hi_i,
  input  logic [WIDTH-1:0] du_lo_i,
  input  logic             du_ff_i,
  output logic             err_o
);

  localparam logic [3:0] c_OP_MTHI = 4'b0100;
  localparam logic [3:0] c_OP_MTLO = 4'b0101;
  localparam logic [3:0] c_OP_MFHI = 4'b0110;
  localparam logic [3:0] c_OP_MFLO = 4'b0111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] du_a_q;
  logic [WIDTH-1:0] du_b_q;
  logic [3:0]       du_m_q;
  logic             du_en_q;
  // Previous-cycle busy flag; completion is the busy falling edge.
  logic             ff_q;

  logic w_is_muldiv;
  logic w_accept;
  logic w_done;

  // MULT/DIV/MULTU/DIVU are exactly the x00x opcodes.
  assign w_is_muldiv = (op_i[2:1] == 2'b00);
  assign w_accept    = (state_q == ST_IDLE) && op_valid_i && w_is_muldiv;
  assign w_done      = ff_q && !du_ff_i;

`ifdef HILO_TIMEOUT_EN
  localparam int c_CNT_W = (TMO > 1) ? $clog2(TMO) : 1;
  logic [c_CNT_W-1:0] wait_cnt_q;
  logic               err_q;
  assign err_o = err_q;
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TMO == 0);
  assign err_o        = 1'b0;
`endif

  // The accept cycle stalls combinationally so the op is held until ISSUE.
  assign stall_o = w_accept || (state_q == ST_ISSUE) || (state_q == ST_WAIT);

  // Reads are only serviced in IDLE; anything arriving while busy is stalled.
  always_comb begin
    mf_data_o = '0;
    if ((state_q == ST_IDLE) && op_valid_i) begin
      if (op_i == c_OP_MFHI) begin
        mf_data_o = hi_q;
      end else if (op_i == c_OP_MFLO) begin
        mf_data_o = lo_q;
      end
    end
  end

  assign du_a_o  = du_a_q;
  assign du_b_o  = du_b_q;
  assign du_m_o  = du_m_q;
  assign du_en_o = du_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      hi_q       <= '0;
      lo_q       <= '0;
      du_a_q     <= '0;
      du_b_q     <= '0;
      du_m_q     <= '0;
      du_en_q    <= 1'b0;
      ff_q       <= 1'b0;
`ifdef HILO_TIMEOUT_EN
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      du_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            du_b_q  <= rs_val_i;
            du_a_q  <= rt_val_i;
            du_m_q  <= op_i;
            du_en_q <= 1'b1;
            state_q <= ST_ISSUE;
          end else if (op_valid_i && (op_i == c_OP_MTHI)) begin
            hi_q <= rs_val_i;
          end else if (op_valid_i && (op_i == c_OP_MTLO)) begin
            lo_q <= rs_val_i;
          end
        end

        ST_ISSUE: begin
          ff_q       <= 1'b0;
`ifdef HILO_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
          state_q    <= ST_WAIT;
        end

        ST_WAIT: begin
          ff_q <= du_ff_i;
          if (w_done) begin
            hi_q    <= du_hi_i;
            lo_q    <= du_lo_i;
            state_q <= ST_WRITE;
          end
`ifdef HILO_TIMEOUT_EN
          // Counter holds the number of WAIT cycles already spent; this is
          // the TMO-th one when it equals TMO-1.
          else if (wait_cnt_q == c_CNT_W'(TMO - 1)) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            wait_cnt_q <= wait_cnt_q + c_CNT_W'(1);
          end
`endif
        end

        ST_WRITE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
